// File: rtl/bubble_pkg.sv
// Shared types and constants for the bubble spawn scheduler.
// Holds the spawn descriptor layout, the FSM encoding and the geometry/colour constants.
package bubble_pkg;

    localparam int unsigned LFSR_W  = 34;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned BAND_W  = 4;
    localparam int unsigned N_BANDS = 16;
    localparam int unsigned ACC_W   = 8;

    localparam int unsigned BUBBLE_H_ACTIVE   = 640;
    localparam int unsigned BUBBLE_V_ACTIVE   = 480;
    localparam int unsigned BUBBLE_MIN_RADIUS = 45;

    // Band that drives the radius in each horizontal quarter of the screen
    localparam int unsigned BAND_Q0 = 1;
    localparam int unsigned BAND_Q1 = 5;
    localparam int unsigned BAND_Q2 = 9;
    localparam int unsigned BAND_Q3 = 13;

    localparam int unsigned COLOUR_SLOPE = 51;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] rad;
        logic [COL_W-1:0]   r;
        logic [COL_W-1:0]   g;
        logic [COL_W-1:0]   b;
    } spawn_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SUM   = 2'd1,
        ST_GEN   = 2'd2,
        ST_OFFER = 2'd3
    } state_t;

endpackage

// File: rtl/bubble_lfsr.sv
// Free-running 34-bit Fibonacci LFSR (taps 34,27,2,1), seeded with 1.
// Advances every cycle; the whole state is exposed as the random word.
module bubble_lfsr
    import bubble_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[33] ^ lfsr_q[26] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_q <= LFSR_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_state = lfsr_q;

endmodule

// File: rtl/bubble_spawn_scheduler.sv
// Frame-synchronous bubble spawn and colour-decay scheduler.
// Evaluates spectrum energy at vertical blanking and offers one spawn descriptor over valid/ready.
module bubble_spawn_scheduler
    import bubble_pkg::*;
#(
    parameter int unsigned SPAWN_FRAMES = 2,
    parameter int unsigned DECAY_FRAMES = 1,
    parameter int unsigned MIN_RADIUS   = BUBBLE_MIN_RADIUS,
    parameter int unsigned H_ACTIVE     = BUBBLE_H_ACTIVE,
    parameter int unsigned V_ACTIVE     = BUBBLE_V_ACTIVE
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_frame_start,
    input  logic                           i_enable,
    input  logic [N_BANDS-1:0][BAND_W-1:0] i_DATA,
    output logic                           o_spawn_valid,
    input  logic                           i_spawn_ready,
    output logic [COORD_W-1:0]             o_spawn_x,
    output logic [COORD_W-1:0]             o_spawn_y,
    output logic [COORD_W-1:0]             o_spawn_rad,
    output logic [COL_W-1:0]               o_spawn_r,
    output logic [COL_W-1:0]               o_spawn_g,
    output logic [COL_W-1:0]               o_spawn_b,
    output logic                           o_decay_tick,
    output logic                           o_busy
);

    localparam int unsigned SPAWN_CNT_W = $clog2(SPAWN_FRAMES + 1);
    localparam int unsigned DECAY_CNT_W = $clog2(DECAY_FRAMES + 1);
    localparam int unsigned QUARTER     = H_ACTIVE / 4;

    state_t                          state_q, state_d;
    logic [1:0]                      sum_idx_q, sum_idx_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [N_BANDS-1:0][BAND_W-1:0]  data_q, data_d;
    logic [LFSR_W-1:0]               rnd_q, rnd_d;
    spawn_t                          spawn_q, spawn_d;
    logic                            spawn_valid_q, spawn_valid_d;
    logic                            decay_tick_q, decay_tick_d;
    logic                            busy_q, busy_d;
    logic [SPAWN_CNT_W-1:0]          spawn_cnt_q, spawn_cnt_d;
    logic [DECAY_CNT_W-1:0]          decay_cnt_q, decay_cnt_d;

    logic [LFSR_W-1:0]  lfsr_state;
    logic [ACC_W-1:0]   group_sum_c;
    logic [ACC_W-1:0]   acc_sum_c;
    spawn_t             desc_c;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    logic [COORD_W-1:0] term_c;
    logic [BAND_W-1:0]  band_c;
    logic [1:0]         quarter_c;
    logic [15:0]        prod_c;
    logic [COL_W-1:0]   slope_c;
    logic               spawn_due_c;
    logic               unused_rnd_c;

    bubble_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_state (lfsr_state)
    );

    // Bits of the snapshot between the radius jitter and the threshold byte carry no meaning
    assign unused_rnd_c = ^rnd_q[25:24];

    // Partial sum of the four bands selected by the SUM beat index
    always_comb begin
        group_sum_c = '0;
        for (int k = 0; k < 4; k++) begin
            group_sum_c = group_sum_c + ACC_W'(data_q[{sum_idx_q, 2'(k)}]);
        end
        acc_sum_c = acc_q + group_sum_c;
    end

    // Descriptor derived from the snapshot: position, quarter colour ramp and radius
    always_comb begin
        x_c = COORD_W'(rnd_q[9:0]);
        if (x_c >= COORD_W'(H_ACTIVE)) begin
            x_c = x_c - COORD_W'(512);
        end
        y_c = COORD_W'(rnd_q[18:10]);
        if (y_c >= COORD_W'(V_ACTIVE)) begin
            y_c = y_c - COORD_W'(256);
        end

        quarter_c = 2'd3;
        band_c    = data_q[BAND_Q3];
        term_c    = COORD_W'(H_ACTIVE - 1) - x_c;
        if (x_c < COORD_W'(QUARTER)) begin
            quarter_c = 2'd0;
            band_c    = data_q[BAND_Q0];
            term_c    = x_c;
        end else if (x_c < COORD_W'(2 * QUARTER)) begin
            quarter_c = 2'd1;
            band_c    = data_q[BAND_Q1];
            term_c    = COORD_W'(2 * QUARTER - 1) - x_c;
        end else if (x_c < COORD_W'(3 * QUARTER)) begin
            quarter_c = 2'd2;
            band_c    = data_q[BAND_Q2];
            term_c    = x_c - COORD_W'(2 * QUARTER);
        end

        prod_c  = 16'(COLOUR_SLOPE) * 16'(term_c);
        slope_c = COL_W'(prod_c >> 5);

        desc_c     = '0;
        desc_c.x   = x_c;
        desc_c.y   = y_c;
        desc_c.rad = COORD_W'(MIN_RADIUS) + (COORD_W'(band_c) << 2) + COORD_W'(rnd_q[23:19]);
        case (quarter_c)
            2'd0: begin
                desc_c.r = 8'hFF;
                desc_c.g = slope_c;
            end
            2'd1: begin
                desc_c.r = slope_c;
                desc_c.g = 8'hFF;
            end
            2'd2: begin
                desc_c.g = 8'hFF;
                desc_c.b = slope_c;
            end
            default: begin
                desc_c.g = slope_c;
                desc_c.b = 8'hFF;
            end
        endcase
    end

    // Frame counters, decay pulse and spawn FSM next-state
    always_comb begin
        state_d       = state_q;
        sum_idx_d     = sum_idx_q;
        acc_d         = acc_q;
        data_d        = data_q;
        rnd_d         = rnd_q;
        spawn_d       = spawn_q;
        spawn_valid_d = spawn_valid_q;
        spawn_cnt_d   = spawn_cnt_q;
        decay_cnt_d   = decay_cnt_q;

        spawn_due_c  = i_frame_start && (spawn_cnt_q == '0);
        decay_tick_d = i_frame_start && (decay_cnt_q == '0);

        if (i_frame_start) begin
            spawn_cnt_d = (spawn_cnt_q == SPAWN_CNT_W'(SPAWN_FRAMES - 1)) ? '0
                        : spawn_cnt_q + SPAWN_CNT_W'(1);
            decay_cnt_d = (decay_cnt_q == DECAY_CNT_W'(DECAY_FRAMES - 1)) ? '0
                        : decay_cnt_q + DECAY_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (spawn_due_c && i_enable) begin
                    state_d   = ST_SUM;
                    data_d    = i_DATA;
                    rnd_d     = lfsr_state;
                    acc_d     = '0;
                    sum_idx_d = '0;
                end
            end
            ST_SUM: begin
                acc_d     = acc_sum_c;
                sum_idx_d = sum_idx_q + 2'd1;
                if (sum_idx_q == 2'd3) begin
                    state_d = (acc_sum_c > rnd_q[33:26]) ? ST_GEN : ST_IDLE;
                end
            end
            ST_GEN: begin
                spawn_d       = desc_c;
                spawn_valid_d = 1'b1;
                state_d       = ST_OFFER;
            end
            ST_OFFER: begin
                if (i_spawn_ready) begin
                    spawn_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            sum_idx_q     <= '0;
            acc_q         <= '0;
            data_q        <= '0;
            rnd_q         <= '0;
            spawn_q       <= '0;
            spawn_valid_q <= 1'b0;
            decay_tick_q  <= 1'b0;
            busy_q        <= 1'b0;
            spawn_cnt_q   <= '0;
            decay_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sum_idx_q     <= sum_idx_d;
            acc_q         <= acc_d;
            data_q        <= data_d;
            rnd_q         <= rnd_d;
            spawn_q       <= spawn_d;
            spawn_valid_q <= spawn_valid_d;
            decay_tick_q  <= decay_tick_d;
            busy_q        <= busy_d;
            spawn_cnt_q   <= spawn_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
        end
    end

    assign o_spawn_valid = spawn_valid_q;
    assign o_spawn_x     = spawn_q.x;
    assign o_spawn_y     = spawn_q.y;
    assign o_spawn_rad   = spawn_q.rad;
    assign o_spawn_r     = spawn_q.r;
    assign o_spawn_g     = spawn_q.g;
    assign o_spawn_b     = spawn_q.b;
    assign o_decay_tick  = decay_tick_q;
    assign o_busy        = busy_q;

endmodule
